// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the fetch/data memory arbiter
package mem_arbiter_pkg;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } mem_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_e;

  localparam logic [3:0] BE_WORD = 4'hF;

  // Data port wins ties: the M-stage instruction is older than the one being fetched.
  function automatic logic pick_dm(input logic if_ok, input logic dm_ok);
    return dm_ok | ~if_ok;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one single-port memory bus
// One outstanding transaction; completion cycle may grant the other requester.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [31:0]     if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [3:0]      dm_be,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [XLEN-1:0] dm_rdata,
  output logic            bus_req,
  output logic            bus_we,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e      state_q, state_d;
  mem_owner_e      owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic arb_en;
  logic if_ok;
  logic dm_ok;
  logic done;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    if_rvalid   = 1'b0;
    dm_rvalid   = 1'b0;
    if_rdata    = '0;
    dm_rdata    = '0;
    timeout_err = 1'b0;
    arb_en      = 1'b0;
    done        = 1'b0;
    if_ok       = if_req;
    dm_ok       = dm_req;

    case (state_q)
      ARB_IDLE: arb_en = 1'b1;
      ARB_REQ: begin
        if (bus_gnt) begin
          state_d = ARB_WAIT;
          cnt_d   = '0;
        end
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          done    = 1'b1;
          state_d = ARB_IDLE;
          arb_en  = 1'b1;
          // The owner's req is still the one just served, so skip it this cycle.
          if (owner_q == OWN_DM) dm_ok = 1'b0;
          else                   if_ok = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          done        = 1'b1;
          timeout_err = 1'b1;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (done) begin
      if (owner_q == OWN_DM) begin
        dm_rvalid = 1'b1;
        dm_rdata  = bus_rvalid ? bus_rdata : '0;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = bus_rvalid ? bus_rdata[31:0] : '0;
      end
    end

    if (arb_en && (if_ok || dm_ok)) begin
      state_d = ARB_REQ;
      if (pick_dm(if_ok, dm_ok)) begin
        owner_d = OWN_DM;
        we_d    = dm_we;
        be_d    = dm_we ? dm_be : BE_WORD;
        addr_d  = dm_addr;
        wdata_d = dm_wdata;
        dm_gnt  = 1'b1;
      end else begin
        owner_d = OWN_IF;
        we_d    = 1'b0;
        be_d    = BE_WORD;
        addr_d  = if_addr;
        wdata_d = '0;
        if_gnt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus_req   = (state_q == ARB_REQ);
  assign bus_we    = we_q;
  assign bus_be    = be_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign stall_if  = if_req & ~if_rvalid;
  assign stall_mem = dm_req & ~dm_rvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Vector table, directed corner sequences, then randomized traffic vs a transaction model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        stall_if, stall_mem, timeout_err;

  mem_arbiter #(.XLEN(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic ifr; logic [31:0] ia; logic dr; logic dwe; logic [3:0] dbe;
    logic [31:0] da; logic [31:0] dwd; logic bg; logic brv; logic [31:0] brd;
  } ins_t;

  typedef struct packed {
    logic ig; logic irv; logic [31:0] ird; logic dg; logic drv; logic [31:0] drd;
    logic breq; logic bwe; logic [3:0] bbe; logic [31:0] baddr; logic [31:0] bwd;
    logic sif; logic smem;
  } outs_t;

  typedef struct packed { ins_t i; outs_t o; } vec_t;

  typedef struct {
    logic own_dm; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
  } txn_t;

  vec_t        vt [19];
  outs_t       act;
  txn_t        tq [$];
  txn_t        t;
  logic [31:0] mem [64];
  logic        f_pend, f_wait, d_pend, d_wait, d_we;
  logic [31:0] f_addr, d_addr, d_wdata, exp_f, exp_d, m_data;
  logic [3:0]  d_be;
  logic        m_busy, gen;
  int          m_cnt, done_f, done_d, n, tpulses;

  task automatic zero_inputs();
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_be = '0;
    dm_addr = '0; dm_wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  task automatic check_all_zero(input string nm);
    chk(nm, {bus_req, bus_we, bus_be, if_gnt, dm_gnt, if_rvalid, dm_rvalid, timeout_err}, 64'h0);
    chk({nm, "_bus"}, {bus_addr, bus_wdata}, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ins: ifr ia dr dwe dbe da dwd bg brv brd | outs: ig irv ird dg drv drd breq bwe bbe baddr bwd sif smem
    vt[0]  = '{'{1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0},
               '{1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,1'b0}};
    vt[1]  = '{'{1'b0,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,1'b0,4'hF,32'h100,32'h0,1'b0,1'b0}};
    vt[2]  = '{'{1'b0,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b1,32'h00500093},
               '{1'b0,1'b1,32'h00500093,1'b0,1'b0,32'h0,1'b0,1'b0,4'hF,32'h100,32'h0,1'b0,1'b0}};
    vt[3]  = '{'{1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b1,32'h1234},
               '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0,4'hF,32'h100,32'h0,1'b0,1'b0}};
    vt[4]  = '{'{1'b1,32'h200,1'b1,1'b1,4'hF,32'h2000,32'hDEADBEEF,1'b0,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0,4'hF,32'h100,32'h0,1'b1,1'b1}};
    vt[5]  = '{'{1'b1,32'h200,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,1'b1,4'hF,32'h2000,32'hDEADBEEF,1'b1,1'b0}};
    vt[6]  = '{'{1'b1,32'h200,1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,1'b1,4'hF,32'h2000,32'hDEADBEEF,1'b1,1'b0}};
    vt[7]  = '{'{1'b1,32'h200,1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b1,4'hF,32'h2000,32'hDEADBEEF,1'b1,1'b0}};
    vt[8]  = '{'{1'b1,32'h200,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b1,32'h11112222},
               '{1'b1,1'b0,32'h0,1'b0,1'b1,32'h11112222,1'b0,1'b1,4'hF,32'h2000,32'hDEADBEEF,1'b1,1'b0}};
    vt[9]  = '{'{1'b0,32'h200,1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,1'b0,4'hF,32'h200,32'h0,1'b0,1'b0}};
    vt[10] = '{'{1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b1,32'h13},
               '{1'b0,1'b1,32'h13,1'b0,1'b0,32'h0,1'b0,1'b0,4'hF,32'h200,32'h0,1'b0,1'b0}};
    vt[11] = '{'{1'b0,32'h0,1'b1,1'b0,4'h0,32'h3000,32'h0,1'b0,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0,4'hF,32'h200,32'h0,1'b0,1'b1}};
    vt[12] = '{'{1'b1,32'h300,1'b1,1'b0,4'h0,32'h3000,32'h0,1'b1,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,1'b0,4'hF,32'h3000,32'h0,1'b1,1'b1}};
    vt[13] = '{'{1'b1,32'h300,1'b1,1'b0,4'h0,32'h3000,32'h0,1'b0,1'b1,32'hCAFEF00D},
               '{1'b1,1'b0,32'h0,1'b0,1'b1,32'hCAFEF00D,1'b0,1'b0,4'hF,32'h3000,32'h0,1'b1,1'b0}};
    vt[14] = '{'{1'b0,32'h300,1'b1,1'b0,4'h0,32'h3004,32'h0,1'b1,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,1'b0,4'hF,32'h300,32'h0,1'b0,1'b1}};
    vt[15] = '{'{1'b0,32'h300,1'b1,1'b0,4'h0,32'h3004,32'h0,1'b0,1'b1,32'h93},
               '{1'b0,1'b1,32'h93,1'b1,1'b0,32'h0,1'b0,1'b0,4'hF,32'h300,32'h0,1'b0,1'b1}};
    vt[16] = '{'{1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,1'b0,4'hF,32'h3004,32'h0,1'b0,1'b0}};
    vt[17] = '{'{1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,1'b0,32'h0},
               '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,1'b0,4'hF,32'h3004,32'h0,1'b0,1'b0}};
    vt[18] = '{'{1'b0,32'h0,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,1'b1,32'h77},
               '{1'b0,1'b0,32'h0,1'b0,1'b1,32'h77,1'b0,1'b0,4'hF,32'h3004,32'h0,1'b0,1'b0}};

    zero_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;

    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      if_req = vt[k].i.ifr; if_addr = vt[k].i.ia; dm_req = vt[k].i.dr; dm_we = vt[k].i.dwe;
      dm_be = vt[k].i.dbe; dm_addr = vt[k].i.da; dm_wdata = vt[k].i.dwd;
      bus_gnt = vt[k].i.bg; bus_rvalid = vt[k].i.brv; bus_rdata = vt[k].i.brd;
      #1;
      act = '{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, bus_req, bus_we,
              bus_be, bus_addr, bus_wdata, stall_if, stall_mem};
      checks++;
      if (act !== vt[k].o) begin
        errors++;
        $display("FAIL vector[%0d]: got %h expected %h", k, act, vt[k].o);
      end
    end

    // Slow memory: grant withheld for five cycles.
    @(negedge clk); zero_inputs(); dm_req = 1'b1; dm_addr = 32'h4000; #1;
    chk("slow_dm_gnt", dm_gnt, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); dm_req = 1'b0; #1;
      chk("slow_bus_req", bus_req, 1);
      chk("slow_bus_addr", bus_addr, 32'h4000);
    end
    @(negedge clk); bus_gnt = 1'b1; #1;
    chk("slow_gnt_cycle", {bus_req, bus_addr}, {1'b1, 32'h4000});
    @(negedge clk); bus_gnt = 1'b0; #1;
    chk("slow_single_issue", bus_req, 0);
    @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'hABCD; #1;
    chk("slow_rvalid", {dm_rvalid, dm_rdata}, {1'b1, 32'hABCD});
    @(negedge clk); bus_rvalid = 1'b0; #1;
    chk("slow_idle_after", bus_req, 0);

    // Timeout: memory grants but never responds; forced at counter == 255 (256th wait cycle).
    @(negedge clk); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h3; dm_addr = 32'h5000; dm_wdata = 32'h12345678; #1;
    chk("tmo_dm_gnt", dm_gnt, 1);
    @(negedge clk); zero_inputs(); bus_gnt = 1'b1; bus_rdata = 32'hFFFFFFFF; #1;
    chk("tmo_bus_be", {bus_req, bus_we, bus_be}, {1'b1, 1'b1, 4'h3});
    n = 0; tpulses = 0;
    while (n < 400) begin
      @(negedge clk); bus_gnt = 1'b0; #1;
      n++;
      if (timeout_err) tpulses++;
      if (dm_rvalid) break;
    end
    chk("tmo_cycles", n, 256);
    chk("tmo_rdata", dm_rdata, 32'h0);
    chk("tmo_err", timeout_err, 1);
    @(negedge clk); #1;
    if (timeout_err) tpulses++;
    chk("tmo_pulse_once", tpulses, 1);
    chk("tmo_idle", {bus_req, dm_rvalid}, 0);
    @(negedge clk); if_req = 1'b1; if_addr = 32'h500; #1;
    chk("tmo_then_if_gnt", if_gnt, 1);
    @(negedge clk); if_req = 1'b0; bus_gnt = 1'b1; #1;
    @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h55; #1;
    chk("tmo_then_if_rvalid", {if_rvalid, if_rdata}, {1'b1, 32'h55});

    // Reset in the wait state, then a stale response after release.
    @(negedge clk); zero_inputs(); if_req = 1'b1; if_addr = 32'h600; #1;
    chk("rst_if_gnt", if_gnt, 1);
    @(negedge clk); if_req = 1'b0; bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 1'b0; #1;
    rst = 1'b1; #1;
    check_all_zero("rst_mid_wait");
    @(negedge clk); rst = 1'b0;
    @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'h5; #1;
    chk("rst_late_rvalid", {if_rvalid, dm_rvalid, bus_req}, 0);
    @(negedge clk); bus_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h700; #1;
    chk("rst_next_if_gnt", if_gnt, 1);
    @(negedge clk); if_req = 1'b0; bus_gnt = 1'b1; #1;
    chk("rst_next_bus", {bus_req, bus_addr}, {1'b1, 32'h700});
    @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h13; #1;
    chk("rst_next_rvalid", {if_rvalid, if_rdata}, {1'b1, 32'h13});

    // Randomized traffic against a transaction-level memory model.
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    f_pend = 1'b0; f_wait = 1'b0; d_pend = 1'b0; d_wait = 1'b0;
    d_we = 1'b0; d_be = '0; f_addr = '0; d_addr = '0; d_wdata = '0;
    exp_f = '0; exp_d = '0; m_data = '0; m_busy = 1'b0; m_cnt = 0;
    done_f = 0; done_d = 0; gen = 1'b1;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      if (cyc == 3000) gen = 1'b0;
      if (!gen && !f_pend && !f_wait && !d_pend && !d_wait) break;
      @(negedge clk);
      if (gen && !f_pend && !f_wait && $urandom_range(2) == 0) begin
        f_pend = 1'b1; f_addr = 32'($urandom_range(63)) << 2;
      end
      if (gen && !d_pend && !d_wait && $urandom_range(2) == 0) begin
        d_pend = 1'b1; d_we = 1'($urandom_range(1)); d_be = 4'($urandom_range(15));
        d_addr = 32'($urandom_range(63)) << 2; d_wdata = $urandom;
      end
      if_req = f_pend; if_addr = f_pend ? f_addr : $urandom;
      dm_req = d_pend; dm_we = d_we; dm_be = d_be; dm_addr = d_addr; dm_wdata = d_wdata;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (m_busy) begin
        chk("rand_one_outstanding", bus_req, 0);
        if (m_cnt == 0) begin
          bus_rvalid = 1'b1; bus_rdata = m_data; m_busy = 1'b0; m_cnt = $urandom_range(3);
        end else m_cnt--;
      end else if (bus_req) begin
        if (m_cnt == 0) begin
          bus_gnt = 1'b1;
          chk("rand_txn_expected", tq.size() > 0, 1);
          if (tq.size() > 0) begin
            t = tq.pop_front();
            chk("rand_bus_fields", {bus_we, bus_be, bus_addr}, {t.we, t.be, t.addr});
            if (t.we) begin
              chk("rand_bus_wdata", bus_wdata, t.wdata);
              for (int b = 0; b < 4; b++)
                if (t.be[b]) mem[t.addr[7:2]][8*b +: 8] = t.wdata[8*b +: 8];
              m_data = $urandom;
            end else m_data = mem[t.addr[7:2]];
            if (t.own_dm) exp_d = m_data; else exp_f = m_data;
          end
          m_busy = 1'b1; m_cnt = $urandom_range(2);
        end else m_cnt--;
      end
      #1;
      chk("rand_stall", {stall_if, stall_mem}, {if_req && !if_rvalid, dm_req && !dm_rvalid});
      if (if_gnt && dm_gnt) chk("rand_dual_gnt", 1, 0);
      if (if_gnt) chk("rand_priority", dm_req && !dm_rvalid, 0);
      if (dm_gnt) begin
        chk("rand_dm_gnt_req", d_pend, 1);
        tq.push_back('{1'b1, d_we, d_we ? d_be : 4'hF, d_addr, d_wdata});
        d_pend = 1'b0; d_wait = 1'b1;
      end
      if (if_gnt) begin
        chk("rand_if_gnt_req", f_pend, 1);
        tq.push_back('{1'b0, 1'b0, 4'hF, f_addr, 32'h0});
        f_pend = 1'b0; f_wait = 1'b1;
      end
      if (if_rvalid) begin
        chk("rand_if_rvalid", {f_wait, if_rdata}, {1'b1, exp_f});
        f_wait = 1'b0; done_f++;
      end else if (if_rdata != 0) chk("rand_if_rdata_zero", if_rdata, 0);
      if (dm_rvalid) begin
        chk("rand_dm_rvalid", {d_wait, dm_rdata}, {1'b1, exp_d});
        d_wait = 1'b0; done_d++;
      end else if (dm_rdata != 0) chk("rand_dm_rdata_zero", dm_rdata, 0);
      if (timeout_err) chk("rand_no_timeout", timeout_err, 0);
    end
    chk("rand_drained", {f_pend, f_wait, d_pend, d_wait}, 0);
    chk("rand_queue_empty", tq.size(), 0);
    chk("rand_activity", (done_f > 20) && (done_d > 20), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
